// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM pipeline stage controller. Runs load/store accesses on a
//               req/gnt/rvalid data-memory handshake, stalls the front of the
//               pipeline until each access completes, and drives the MEM/WB
//               register. Non-memory instructions pass through in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int PC_WIDTH       = 12,
    parameter int DATA_WIDTH     = 16,
    parameter int REGADDR_WIDTH  = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    // EX/MEM register
    input  logic                     mem_reg_write,
    input  logic                     mem_mem_read,
    input  logic                     mem_mem_write,
    input  logic [PC_WIDTH-1:0]      mem_pc,
    input  logic [DATA_WIDTH-1:0]    mem_alu_result,
    input  logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic [REGADDR_WIDTH-1:0] mem_rd,
    // data memory
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [DATA_WIDTH-1:0]    dmem_addr,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    input  logic                     dmem_gnt,
    input  logic                     dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata,
    // pipeline control / status
    output logic                     stall,
    output logic                     dmem_err,
    // MEM/WB register
    output logic                     wb_reg_write,
    output logic                     wb_mem_to_reg,
    output logic [DATA_WIDTH-1:0]    wb_alu_result,
    output logic [DATA_WIDTH-1:0]    wb_read_data,
    output logic [REGADDR_WIDTH-1:0] wb_rd,
    output logic [PC_WIDTH-1:0]      wb_pc
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_load_buf;
    logic                  w_op;
    logic                  w_timeout;

    assign w_op      = mem_mem_read | mem_mem_write;
    assign w_timeout = (r_cnt == c_CNT_MAX);

    // Memory interface: request follows the REQ state, payload comes straight
    // from EX/MEM. A read+write combination is issued as a store.
    assign dmem_req   = (r_state == S_REQ);
    assign dmem_we    = mem_mem_write;
    assign dmem_addr  = mem_alu_result;
    assign dmem_wdata = mem_write_data;

    // Hold the front of the pipeline while an access is being started or is
    // outstanding; released during reset so nothing upstream freezes.
    assign stall = ~reset & (((r_state == S_IDLE) & w_op) |
                             (r_state == S_REQ) | (r_state == S_WAIT));

    // Access FSM with timeout counter, load buffer and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_load_buf <= '0;
            dmem_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_op) begin
                        r_state <= S_REQ;
                        r_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        // stores (including read+write) need no read data
                        r_state <= mem_mem_write ? S_DONE : S_WAIT;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state    <= S_DONE;
                        r_load_buf <= '0;
                        dmem_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        r_state    <= S_DONE;
                        r_load_buf <= dmem_rdata;
                    end else if (w_timeout) begin
                        r_state    <= S_DONE;
                        r_load_buf <= '0;
                        dmem_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // MEM/WB register: load when the stage is free, insert a bubble otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
            wb_rd         <= '0;
            wb_pc         <= '0;
        end else if (!stall) begin
            wb_reg_write  <= mem_reg_write;
            wb_mem_to_reg <= mem_mem_read & ~mem_mem_write;
            wb_alu_result <= mem_alu_result;
            wb_read_data  <= r_load_buf;
            wb_rd         <= mem_rd;
            wb_pc         <= mem_pc;
        end else begin
            wb_reg_write  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Scoreboard bench for mem_stage_ctrl. Directed instructions are
//               issued with hand-computed MEM/WB results; a monitor pops and
//               compares each result as the MEM/WB register loads. A memory
//               responder supplies configurable gnt/rvalid timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic [11:0] mem_pc;
    logic [15:0] mem_alu_result, mem_write_data;
    logic [2:0]  mem_rd;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [15:0] dmem_rdata;
    logic        stall, dmem_err;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [15:0] wb_alu_result, wb_read_data;
    logic [2:0]  wb_rd;
    logic [11:0] wb_pc;

    mem_stage_ctrl #(
        .PC_WIDTH(12), .DATA_WIDTH(16), .REGADDR_WIDTH(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_pc(mem_pc),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
        .mem_rd(mem_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .stall(stall), .dmem_err(dmem_err),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
        .wb_rd(wb_rd), .wb_pc(wb_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [15:0] alu;
        logic [15:0] rdata;
        logic [2:0]  rd;
        logic [11:0] pc;
    } wb_t;

    wb_t q_exp[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  req_cycles = 0;

    // memory responder configuration
    int          m_gnt_dly = 0;
    int          m_rv_dly  = 1;
    logic        m_no_gnt  = 1'b0;
    logic        m_rv_junk = 1'b0;
    logic [15:0] m_rdata   = '0;
    logic        m_exp_we  = 1'b0;
    logic [15:0] m_exp_addr = '0;
    logic [15:0] m_exp_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mem_cfg(input int gd, input int rvd, input logic ng, input logic junk,
                           input logic [15:0] rdata, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata);
        m_gnt_dly = gd; m_rv_dly = rvd; m_no_gnt = ng; m_rv_junk = junk;
        m_rdata = rdata; m_exp_we = we; m_exp_addr = addr; m_exp_wdata = wdata;
    endtask

    // Memory model: grants after m_gnt_dly request cycles, returns load data
    // m_rv_dly cycles after the grant. Optional junk rvalid in the grant cycle.
    initial begin
        int req_cnt = 0;
        int since   = 0;
        logic rv_pend = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
            if (rv_pend) begin
                since++;
                if (since == m_rv_dly) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = m_rdata;
                    rv_pend     = 1'b0;
                end
            end
            if (dmem_req && !reset) begin
                req_cycles++;
                if (!m_no_gnt && req_cnt == m_gnt_dly) begin
                    dmem_gnt = 1'b1;
                    check("dmem_we", 32'(dmem_we), 32'(m_exp_we));
                    check("dmem_addr", 32'(dmem_addr), 32'(m_exp_addr));
                    if (m_exp_we) check("dmem_wdata", 32'(dmem_wdata), 32'(m_exp_wdata));
                    if (!m_exp_we) begin
                        rv_pend = 1'b1;
                        since   = 0;
                    end
                    if (m_rv_junk) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = 16'h0BAD;
                    end
                end
                req_cnt++;
            end else begin
                req_cnt = 0;
            end
        end
    end

    // Monitor: every MEM/WB load that follows an issued instruction is compared.
    initial begin
        wb_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_vec++;
                if ({wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_read_data, wb_rd, wb_pc} !== e) begin
                    n_err++;
                    $display("FAIL wb pc=%0h: got rw=%0b m2r=%0b alu=%0h rdata=%0h rd=%0d pc=%0h expected rw=%0b m2r=%0b alu=%0h rdata=%0h rd=%0d pc=%0h",
                             e.pc, wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_read_data, wb_rd, wb_pc,
                             e.rw, e.m2r, e.alu, e.rdata, e.rd, e.pc);
                end
            end
        end
    end

    // Present one instruction (called at posedge+1), wait until the stage lets
    // it go, queue its expected MEM/WB contents, and report stalls observed.
    task automatic issue(input logic rw, input logic mr, input logic mw,
                         input logic [11:0] pc, input logic [15:0] alu,
                         input logic [15:0] wd, input logic [2:0] rd,
                         input logic exp_m2r, input logic [15:0] exp_rdata,
                         output int stalls, output logic rw_at_done);
        wb_t e;
        mem_reg_write = rw; mem_mem_read = mr; mem_mem_write = mw;
        mem_pc = pc; mem_alu_result = alu; mem_write_data = wd; mem_rd = rd;
        stalls = 0;
        rw_at_done = 1'bx;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 64) begin
                n_vec++; n_err++;
                $display("FAIL issue_timeout pc=%0h: stall held 64 cycles, expected release", pc);
                break;
            end
        end
        rw_at_done = wb_reg_write;
        e.rw = rw; e.m2r = exp_m2r; e.alu = alu; e.rdata = exp_rdata; e.rd = rd; e.pc = pc;
        if (stalls <= 64) q_exp.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0;
        mem_pc = '0; mem_alu_result = '0; mem_write_data = '0; mem_rd = '0;
    endtask

    initial begin
        int   st;
        int   r0;
        logic rwd;
        reset = 1'b1;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        check("reset_req", 32'(dmem_req), 0);
        check("reset_stall", 32'(stall), 0);
        check("reset_err", 32'(dmem_err), 0);
        check("reset_wb", {wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_rd, wb_pc}, 0);
        check("reset_wb_rdata", 32'(wb_read_data), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: ALU op passes in one cycle, no memory request
        r0 = req_cycles;
        issue(1, 0, 0, 12'h004, 16'h1234, 16'h0000, 3'd5, 0, 16'h0000, st, rwd);
        check("alu_stalls", 32'(st), 0);
        check("alu_req_cycles", 32'(req_cycles - r0), 0);

        // 2: load, gnt after 2 extra cycles, data 3 cycles after gnt;
        //    junk rvalid alongside gnt must be ignored
        mem_cfg(2, 3, 0, 1, 16'hBEEF, 0, 16'h0040, 16'h0000);
        r0 = req_cycles;
        issue(1, 1, 0, 12'h008, 16'h0040, 16'h0000, 3'd1, 1, 16'hBEEF, st, rwd);
        check("load_stalls", 32'(st), 7);
        check("load_req_cycles", 32'(req_cycles - r0), 3);
        check("load_bubble", 32'(rwd), 0);

        // 3: store with immediate gnt; load buffer keeps BEEF
        mem_cfg(0, 1, 0, 0, 16'h0000, 1, 16'h0010, 16'hCAFE);
        r0 = req_cycles;
        issue(0, 0, 1, 12'h00C, 16'h0010, 16'hCAFE, 3'd0, 0, 16'hBEEF, st, rwd);
        check("store_stalls", 32'(st), 2);
        check("store_req_cycles", 32'(req_cycles - r0), 1);

        // 4: load that is never granted times out after 16 request cycles
        mem_cfg(0, 1, 1, 0, 16'h0000, 0, 16'h0050, 16'h0000);
        r0 = req_cycles;
        issue(1, 1, 0, 12'h010, 16'h0050, 16'h0000, 3'd3, 1, 16'h0000, st, rwd);
        check("tmo_stalls", 32'(st), 17);
        check("tmo_req_cycles", 32'(req_cycles - r0), 16);
        check("tmo_err", 32'(dmem_err), 1);
        issue(1, 0, 0, 12'h014, 16'h00AA, 16'h0000, 3'd4, 0, 16'h0000, st, rwd);
        check("tmo_alu_stalls", 32'(st), 0);
        check("tmo_err_sticky", 32'(dmem_err), 1);

        // 5: reset while waiting for read data; late rvalid must be ignored
        mem_cfg(0, 3, 0, 0, 16'hDEAD, 0, 16'h0080, 16'h0000);
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_mem_write = 1'b0;
        mem_pc = 12'h030; mem_alu_result = 16'h0080; mem_write_data = '0; mem_rd = 3'd2;
        @(negedge clk);   // IDLE
        @(negedge clk);   // REQ, granted
        @(negedge clk);   // WAIT
        #1;
        check("wait_stall", 32'(stall), 1);
        reset = 1'b1;
        #1;
        check("rst_mid_req", 32'(dmem_req), 0);
        check("rst_mid_stall", 32'(stall), 0);
        check("rst_mid_err", 32'(dmem_err), 0);
        check("rst_mid_wb", {wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_rd, wb_pc}, 0);
        check("rst_mid_wb_rdata", 32'(wb_read_data), 0);
        set_nop();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        r0 = req_cycles;
        issue(1, 0, 0, 12'h018, 16'h5555, 16'h0000, 3'd6, 0, 16'h0000, st, rwd);
        check("post_rst_stalls", 32'(st), 0);
        check("post_rst_req", 32'(req_cycles - r0), 0);

        // 6: back-to-back loads with immediate gnt and rvalid
        r0 = req_cycles;
        mem_cfg(0, 1, 0, 0, 16'h1111, 0, 16'h0100, 16'h0000);
        issue(1, 1, 0, 12'h01C, 16'h0100, 16'h0000, 3'd1, 1, 16'h1111, st, rwd);
        check("b2b_1_stalls", 32'(st), 3);
        mem_cfg(0, 1, 0, 0, 16'h2222, 0, 16'h0102, 16'h0000);
        issue(1, 1, 0, 12'h020, 16'h0102, 16'h0000, 3'd2, 1, 16'h2222, st, rwd);
        check("b2b_2_stalls", 32'(st), 3);
        check("b2b_bubble", 32'(rwd), 0);
        check("b2b_req_cycles", 32'(req_cycles - r0), 2);

        // 7: read and write together behave as a store
        mem_cfg(0, 1, 0, 0, 16'h0000, 1, 16'h0200, 16'h7777);
        r0 = req_cycles;
        issue(0, 1, 1, 12'h024, 16'h0200, 16'h7777, 3'd7, 0, 16'h2222, st, rwd);
        check("rw_both_stalls", 32'(st), 2);
        check("rw_both_req", 32'(req_cycles - r0), 1);

        set_nop();
        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(q_exp.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
